// File: rtl/divider_16.sv
// rtl/divider_16.sv - signed Q2.13 sequential restoring divider with saturation and divide-by-zero flags
module divider_16 (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_VLD,
  input  logic [15:0] I_DIVIDEND,
  input  logic [15:0] I_DIVISOR,
  output logic        O_VLD,
  output logic        O_DIV_BUSY,
  output logic [15:0] O_QUOTIENT,
  output logic        O_OVF,
  output logic        O_DIV_ZERO
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // Partial remainder; always < |divisor| between iterations, so 16 bits suffice.
  logic [15:0] rem_q, rem_d;
  // Remaining low bits of the 29-bit shifted dividend, consumed MSB first.
  logic [14:0] shf_q, shf_d;
  logic [15:0] dsr_q, dsr_d;
  logic [14:0] quo_q, quo_d;
  logic        sign_q, sign_d;
  logic        dsign_q, dsign_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;
  logic [15:0] res_q, res_d;
  logic        res_ovf_q, res_ovf_d;
  logic        res_zero_q, res_zero_d;

  logic [15:0] abs_dividend;
  logic [15:0] abs_divisor;
  logic        ovf_in;
  logic [16:0] trial;
  logic        qbit;

  // Operand magnitudes and the early overflow test used at accept time.
  always_comb begin
    abs_dividend = I_DIVIDEND[15] ? (16'd0 - I_DIVIDEND) : I_DIVIDEND;
    abs_divisor  = I_DIVISOR[15]  ? (16'd0 - I_DIVISOR)  : I_DIVISOR;
    ovf_in       = ({2'b00, abs_dividend} >= {abs_divisor, 2'b00}) && (I_DIVISOR != 16'd0);
  end

  // Next-state logic: accept, one quotient bit per DIV cycle, result formatting on DONE entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    shf_d      = shf_q;
    dsr_d      = dsr_q;
    quo_d      = quo_q;
    sign_d     = sign_q;
    dsign_d    = dsign_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    res_d      = res_q;
    res_ovf_d  = res_ovf_q;
    res_zero_d = res_zero_q;
    trial      = {rem_q, shf_q[14]};
    qbit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_VLD) begin
          state_d = ST_DIV;
          cnt_d   = 4'd0;
          // Top 14 bits of (|dividend| << 13) seed the remainder; below |divisor| when not overflowing.
          rem_d   = {2'b00, abs_dividend[15:2]};
          shf_d   = {abs_dividend[1:0], 13'd0};
          dsr_d   = abs_divisor;
          quo_d   = 15'd0;
          sign_d  = I_DIVIDEND[15] ^ I_DIVISOR[15];
          dsign_d = I_DIVIDEND[15];
          ovf_d   = ovf_in;
          zero_d  = (I_DIVISOR == 16'd0);
        end
      end

      ST_DIV: begin
        if (trial >= {1'b0, dsr_q}) begin
          // True difference is below |divisor|, so the 16-bit wrap is exact.
          rem_d = trial[15:0] - dsr_q;
          qbit  = 1'b1;
        end else begin
          rem_d = trial[15:0];
        end
        quo_d = {quo_q[13:0], qbit};
        shf_d = {shf_q[13:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd14) begin
          state_d    = ST_DONE;
          cnt_d      = 4'd0;
          res_ovf_d  = ovf_q;
          res_zero_d = zero_q;
          if (zero_q) begin
            res_d = dsign_q ? 16'h8000 : 16'h7FFF;
          end else if (ovf_q) begin
            res_d = sign_q ? 16'h8000 : 16'h7FFF;
          end else if (sign_q && (quo_d != 15'd0)) begin
            res_d = 16'd0 - {1'b0, quo_d};
          end else begin
            res_d = {1'b0, quo_d};
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rem_q      <= 16'd0;
      shf_q      <= 15'd0;
      dsr_q      <= 16'd0;
      quo_q      <= 15'd0;
      sign_q     <= 1'b0;
      dsign_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      res_q      <= 16'd0;
      res_ovf_q  <= 1'b0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      shf_q      <= shf_d;
      dsr_q      <= dsr_d;
      quo_q      <= quo_d;
      sign_q     <= sign_d;
      dsign_q    <= dsign_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      res_q      <= res_d;
      res_ovf_q  <= res_ovf_d;
      res_zero_q <= res_zero_d;
    end
  end

  // Status outputs are plain decodes of the registered state.
  always_comb begin
    O_VLD      = (state_q == ST_DONE);
    O_DIV_BUSY = (state_q != ST_IDLE);
    O_QUOTIENT = res_q;
    O_OVF      = res_ovf_q;
    O_DIV_ZERO = res_zero_q;
  end

endmodule

// File: tb/tb_divider_16.sv
// tb/tb_divider_16.sv - scoreboard bench for divider_16 with directed Q2.13 vectors
module tb_divider_16;

  logic        I_CLK = 1'b0;
  logic        I_RST;
  logic        I_VLD;
  logic [15:0] I_DIVIDEND;
  logic [15:0] I_DIVISOR;
  logic        O_VLD;
  logic        O_DIV_BUSY;
  logic [15:0] O_QUOTIENT;
  logic        O_OVF;
  logic        O_DIV_ZERO;

  divider_16 dut (
    .I_CLK      (I_CLK),
    .I_RST      (I_RST),
    .I_VLD      (I_VLD),
    .I_DIVIDEND (I_DIVIDEND),
    .I_DIVISOR  (I_DIVISOR),
    .O_VLD      (O_VLD),
    .O_DIV_BUSY (O_DIV_BUSY),
    .O_QUOTIENT (O_QUOTIENT),
    .O_OVF      (O_OVF),
    .O_DIV_ZERO (O_DIV_ZERO)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
    logic        dz;
    int          done_cyc;
    bit          chk_gap;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        ovf;
    logic        dz;
  } vec_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_vld_cyc = 0;
  logic [15:0] last_q = 16'h0000;
  logic        last_ovf = 1'b0;
  logic        last_dz = 1'b0;

  always @(posedge I_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every O_VLD, otherwise checks that results hold.
  always @(negedge I_CLK) begin
    exp_t e;
    if (I_RST) begin
      exp_q.delete();
      last_q   = 16'h0000;
      last_ovf = 1'b0;
      last_dz  = 1'b0;
    end else if (O_VLD) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", {31'd0, O_VLD}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", {16'd0, O_QUOTIENT}, {16'd0, e.q});
        chk("ovf", {31'd0, O_OVF}, {31'd0, e.ovf});
        chk("div_zero", {31'd0, O_DIV_ZERO}, {31'd0, e.dz});
        chk("latency", cyc, e.done_cyc);
        if (e.chk_gap) chk("result_spacing", cyc - last_vld_cyc, 32'd17);
        chk("busy_in_done", {31'd0, O_DIV_BUSY}, 32'd1);
        last_q   = e.q;
        last_ovf = e.ovf;
        last_dz  = e.dz;
      end
      last_vld_cyc = cyc;
    end else begin
      chk("hold", {15'd0, O_QUOTIENT, O_OVF, O_DIV_ZERO}, {15'd0, last_q, last_ovf, last_dz});
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && O_DIV_BUSY; i++) begin
      @(posedge I_CLK);
      #2;
    end
    chk("idle_timeout", {31'd0, O_DIV_BUSY}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge I_CLK);
    #2;
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic push_exp(input vec_t v, input bit gap);
    exp_t e;
    e.q        = v.q;
    e.ovf      = v.ovf;
    e.dz       = v.dz;
    // Accepted on the next edge; DONE is entered 15 edges later (16th busy cycle).
    e.done_cyc = cyc + 1 + 15;
    e.chk_gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input vec_t v);
    wait_idle();
    I_VLD      = 1'b1;
    I_DIVIDEND = v.a;
    I_DIVISOR  = v.b;
    push_exp(v, 1'b0);
    @(posedge I_CLK);
    #2;
    I_VLD = 1'b0;
    chk("busy_after_accept", {31'd0, O_DIV_BUSY}, 32'd1);
    drain();
  endtask

  vec_t dir_vecs[14];
  vec_t cont_vecs[3];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    dir_vecs[0]  = '{16'h2000, 16'h4000, 16'h1000, 1'b0, 1'b0};
    dir_vecs[1]  = '{16'h2000, 16'h6000, 16'h0AAA, 1'b0, 1'b0};
    dir_vecs[2]  = '{16'hE000, 16'h4000, 16'hF000, 1'b0, 1'b0};
    dir_vecs[3]  = '{16'h6000, 16'h1000, 16'h7FFF, 1'b1, 1'b0};
    dir_vecs[4]  = '{16'h8000, 16'h2000, 16'h8000, 1'b1, 1'b0};
    dir_vecs[5]  = '{16'hC000, 16'h0000, 16'h8000, 1'b0, 1'b1};
    dir_vecs[6]  = '{16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    dir_vecs[7]  = '{16'h1000, 16'hE000, 16'hF000, 1'b0, 1'b0};
    dir_vecs[8]  = '{16'h0000, 16'hE000, 16'h0000, 1'b0, 1'b0};
    dir_vecs[9]  = '{16'h5FFF, 16'h1800, 16'h7FFE, 1'b0, 1'b0};
    dir_vecs[10] = '{16'h6000, 16'h1800, 16'h7FFF, 1'b1, 1'b0};
    dir_vecs[11] = '{16'h8000, 16'h8000, 16'h2000, 1'b0, 1'b0};
    dir_vecs[12] = '{16'hFFFF, 16'h2000, 16'hFFFF, 1'b0, 1'b0};
    dir_vecs[13] = '{16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0};

    cont_vecs[0] = '{16'h2000, 16'h4000, 16'h1000, 1'b0, 1'b0};
    cont_vecs[1] = '{16'hE000, 16'hE000, 16'h2000, 1'b0, 1'b0};
    cont_vecs[2] = '{16'h1000, 16'h6000, 16'h0555, 1'b0, 1'b0};

    I_RST      = 1'b1;
    I_VLD      = 1'b0;
    I_DIVIDEND = 16'h0000;
    I_DIVISOR  = 16'h0000;
    repeat (3) @(posedge I_CLK);
    #2;
    I_RST = 1'b0;
    chk("reset_busy", {31'd0, O_DIV_BUSY}, 32'd0);
    chk("reset_vld", {31'd0, O_VLD}, 32'd0);
    chk("reset_outputs", {15'd0, O_QUOTIENT, O_OVF, O_DIV_ZERO}, 32'd0);

    foreach (dir_vecs[i]) run_op(dir_vecs[i]);

    // I_VLD held high; only operands present while the divider is idle may be used.
    begin
      int k = 0;
      I_VLD = 1'b1;
      for (int n = 0; n < 100 && k <= 3; n++) begin
        if (!O_DIV_BUSY && k < 3) begin
          I_DIVIDEND = cont_vecs[k].a;
          I_DIVISOR  = cont_vecs[k].b;
          push_exp(cont_vecs[k], k != 0);
          k++;
        end else if (k == 3 && O_DIV_BUSY) begin
          I_VLD = 1'b0;
          k++;
        end else begin
          I_DIVIDEND = 16'($urandom);
          I_DIVISOR  = 16'($urandom);
        end
        @(posedge I_CLK);
        #2;
      end
      I_VLD = 1'b0;
      chk("continuous_accepts", k, 32'd4);
      drain();
    end

    // Reset during iteration 7 aborts the operation and clears the outputs.
    wait_idle();
    I_VLD      = 1'b1;
    I_DIVIDEND = 16'h2000;
    I_DIVISOR  = 16'h6000;
    @(posedge I_CLK);
    #2;
    I_VLD = 1'b0;
    repeat (7) begin
      @(posedge I_CLK);
      #2;
    end
    I_RST = 1'b1;
    @(posedge I_CLK);
    #2;
    I_RST = 1'b0;
    chk("abort_busy", {31'd0, O_DIV_BUSY}, 32'd0);
    chk("abort_outputs", {15'd0, O_QUOTIENT, O_OVF, O_DIV_ZERO}, 32'd0);
    repeat (20) @(posedge I_CLK);
    #2;

    // Reset wins over a simultaneous request.
    I_RST      = 1'b1;
    I_VLD      = 1'b1;
    I_DIVIDEND = 16'h2000;
    I_DIVISOR  = 16'h2000;
    @(posedge I_CLK);
    #2;
    I_RST = 1'b0;
    I_VLD = 1'b0;
    chk("reset_priority_busy", {31'd0, O_DIV_BUSY}, 32'd0);
    repeat (20) @(posedge I_CLK);
    #2;

    run_op('{16'h4000, 16'h2000, 16'h4000, 1'b0, 1'b0});

    repeat (5) @(posedge I_CLK);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_16.md
DIVIDER_16 -- requirements
Module: divider_16

Interface
REQ-001 SHALL have ports: I_CLK  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: I_RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: I_VLD  input  1  operand valid, single-cycle request.
REQ-004 SHALL have ports: I_DIVIDEND  input  16  signed two's-complement dividend; format Q2.13, so 1.0 = 0x2000.
REQ-005 SHALL have ports: I_DIVISOR  input  16  signed two's-complement divisor, Q2.13.
REQ-006 SHALL have ports: O_VLD  output  1  result valid, one-cycle pulse.
REQ-007 SHALL have ports: O_DIV_BUSY  output  1  operation in progress, request ignored.
REQ-008 SHALL have ports: O_QUOTIENT  output  16  signed Q2.13 quotient, registered.
REQ-009 SHALL have ports: O_OVF  output  1  saturation flag, valid with O_VLD.
REQ-010 SHALL have ports: O_DIV_ZERO  output  1  divisor-zero flag, valid with O_VLD.

Function
REQ-011 SHALL accept an operation on a rising edge where I_VLD=1 and O_DIV_BUSY=0, registering the following:
- |dividend| (16-bit unsigned, so 0x8000 gives 32768);
- |divisor|;
- result sign = dividend[15] XOR divisor[15];
- zero flag = (divisor==0);
- overflow flag = (|dividend| >= 4*|divisor|) AND divisor!=0.
REQ-012 SHALL ignore I_VLD while O_DIV_BUSY=1, with no effect on the current operation.
REQ-013 SHALL compute the magnitude as floor((|dividend| << 13) / |divisor|) by radix-2 restoring division over a 29-bit shifted dividend, producing 15 quotient bits MSB first, one bit per cycle.
REQ-014 SHALL use a states IDLE -> DIV (15 cycles, 4-bit iteration counter 0..14) -> DONE (1 cycle) -> IDLE, with no skipping; latency is fixed regardless of operands or flags.
REQ-015 SHALL assert O_DIV_BUSY from the cycle after the accept edge through the DONE cycle inclusive (16 cycles), and SHALL deassert it on the following cycle.
REQ-016 SHALL assert O_VLD for exactly the DONE cycle, which is 16 cycles after the accept edge; a new request is accepted no earlier than the cycle after DONE.
REQ-017 SHALL load O_QUOTIENT, O_OVF and O_DIV_ZERO on the edge entering DONE, and SHALL hold them unchanged until the next DONE.
REQ-018 SHALL negate the result when the sign is 1 and the magnitude is nonzero; SHALL never produce a negative zero (a zero magnitude outputs 0x0000); rounding is truncation toward zero.
REQ-019 SHALL, when the overflow flag is set, output 0x7FFF if the sign is 0 and 0x8000 if the sign is 1, with O_OVF=1 (this includes the exact case -4.0/1.0).
REQ-020 SHALL, when the divisor is 0, output 0x7FFF if dividend[15]=0 and 0x8000 otherwise, with O_DIV_ZERO=1 and O_OVF=0; 0/0 gives 0x7FFF.
REQ-021 SHALL keep O_OVF=0 and O_DIV_ZERO=0 for all in-range results.
REQ-022 SHALL make the divider datapath width-safe: a 17-bit partial remainder compared against the 16-bit |divisor|; no truncation of an intermediate before the final 15-bit magnitude.

Reset
REQ-023 SHALL, while I_RST=1 at a rising edge, force the following:
- state IDLE;
- counter 0;
- O_VLD=0;
- O_DIV_BUSY=0;
- O_QUOTIENT=0x0000;
- O_OVF=0;
- O_DIV_ZERO=0;
- all internal registers to 0.
REQ-024 SHALL abort any operation in progress when reset is applied mid-operation, with no O_VLD pulse for the aborted operation; the first accept is possible on the first edge after I_RST returns to 0.
REQ-025 SHALL give reset priority over an accept on the same edge.

Verification
REQ-026 SHALL cover: 0x2000 / 0x4000 (1.0/2.0) -> O_VLD 16 cycles after accept, O_QUOTIENT=0x1000, both flags 0.
REQ-027 SHALL cover: 0x2000 / 0x6000 (1.0/3.0) -> 0x0AAA (truncated); 0xE000 / 0x4000 (-1.0/2.0) -> 0xF000.
REQ-028 SHALL cover: 0x6000 / 0x1000 (3.0/0.5) -> 0x7FFF, O_OVF=1; 0x8000 / 0x2000 -> 0x8000, O_OVF=1.
REQ-029 SHALL cover: 0xC000 / 0x0000 -> 0x8000, O_DIV_ZERO=1, O_OVF=0; 0x0000 / 0x0000 -> 0x7FFF, O_DIV_ZERO=1.
REQ-030 SHALL cover: I_VLD held high continuously with changing operands -> only the operands present at accept edges are used, results spaced 17 cycles apart, no O_VLD during busy other than the DONE cycle.
REQ-031 SHALL cover: I_RST pulsed at iteration 7 -> no O_VLD, outputs 0x0000/0/0; the next request 0x4000 / 0x2000 -> 0x4000.
